// File: rtl/vga_bounce_renderer.sv
// vga_bounce_renderer
// Pixel stage that sits behind the VGA timing controller. It draws a solid
// square over a dim grey background. The square moves once per frame,
// bounces off the screen edges and steps through a six-colour palette on
// every bounce.
// Colour and sync outputs are registered together, so they stay aligned
// with exactly one clock of latency.
// Box state only changes on the rising edge of v_sync_in, so a single frame
// is never drawn with two box positions.
module vga_bounce_renderer #(
    parameter int DISP_W   = 640,
    parameter int DISP_H   = 480,
    parameter int BOX_SIZE = 32,
    parameter int SPEED    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    input  logic       frame_active,
    input  logic       pause,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       h_sync,
    output logic       v_sync,
    output logic [7:0] bounce_count
);

    // All position arithmetic is 11 bits wide so that bx+SPEED cannot wrap.
    localparam logic [10:0] X_MAX   = 11'(DISP_W - BOX_SIZE);
    localparam logic [10:0] Y_MAX   = 11'(DISP_H - BOX_SIZE);
    localparam logic [10:0] SPEED_W = 11'(SPEED);
    localparam logic [10:0] BOX_W   = 11'(BOX_SIZE);
    localparam logic [9:0]  X_MAX_P = 10'(DISP_W - BOX_SIZE);
    localparam logic [9:0]  Y_MAX_P = 10'(DISP_H - BOX_SIZE);

    // Box state. For dir_*, 0 means moving toward larger coordinates.
    logic [9:0] bx_q, bx_d;
    logic [9:0] by_q, by_d;
    logic       dir_x_q, dir_x_d;
    logic       dir_y_q, dir_y_d;
    logic [2:0] pal_idx_q, pal_idx_d;
    logic [7:0] bounce_count_q, bounce_count_d;
    logic       vs_prev_q, vs_prev_d;

    // Registered outputs
    logic [1:0] r_q, r_d;
    logic [1:0] g_q, g_d;
    logic [1:0] b_q, b_d;
    logic       h_sync_q, h_sync_d;
    logic       v_sync_q, v_sync_d;

    logic        tick;
    logic [10:0] bx_ext, by_ext, x_ext, y_ext;
    logic [10:0] bx_inc, bx_dec, by_inc, by_dec;
    logic [10:0] bx_end, by_end;
    logic        flip_x, flip_y;
    logic        in_box;
    logic [5:0]  pal_rgb;

    assign tick   = v_sync_in & ~vs_prev_q;
    assign bx_ext = {1'b0, bx_q};
    assign by_ext = {1'b0, by_q};
    assign x_ext  = {1'b0, x};
    assign y_ext  = {1'b0, y};
    assign bx_inc = bx_ext + SPEED_W;
    assign bx_dec = bx_ext - SPEED_W;
    assign by_inc = by_ext + SPEED_W;
    assign by_dec = by_ext - SPEED_W;
    assign bx_end = bx_ext + BOX_W;
    assign by_end = by_ext + BOX_W;

    // Move the box once per unpaused frame tick, clamp at the edges and
    // count a bounce when either axis reverses. A corner hit counts once.
    always_comb begin
        bx_d           = bx_q;
        by_d           = by_q;
        dir_x_d        = dir_x_q;
        dir_y_d        = dir_y_q;
        pal_idx_d      = pal_idx_q;
        bounce_count_d = bounce_count_q;
        vs_prev_d      = v_sync_in;
        flip_x         = 1'b0;
        flip_y         = 1'b0;
        if (tick && !pause) begin
            if (!dir_x_q) begin
                if (bx_inc >= X_MAX) begin
                    bx_d    = X_MAX_P;
                    dir_x_d = 1'b1;
                    flip_x  = 1'b1;
                end else begin
                    bx_d = bx_inc[9:0];
                end
            end else begin
                if (bx_ext <= SPEED_W) begin
                    bx_d    = 10'd0;
                    dir_x_d = 1'b0;
                    flip_x  = 1'b1;
                end else begin
                    bx_d = bx_dec[9:0];
                end
            end
            if (!dir_y_q) begin
                if (by_inc >= Y_MAX) begin
                    by_d    = Y_MAX_P;
                    dir_y_d = 1'b1;
                    flip_y  = 1'b1;
                end else begin
                    by_d = by_inc[9:0];
                end
            end else begin
                if (by_ext <= SPEED_W) begin
                    by_d    = 10'd0;
                    dir_y_d = 1'b0;
                    flip_y  = 1'b1;
                end else begin
                    by_d = by_dec[9:0];
                end
            end
            if (flip_x || flip_y) begin
                pal_idx_d      = (pal_idx_q == 3'd5) ? 3'd0 : pal_idx_q + 3'd1;
                bounce_count_d = bounce_count_q + 8'd1;
            end
        end
    end

    // Palette lookup, packed as {r, g, b}.
    always_comb begin
        pal_rgb = 6'b00_00_00;
        case (pal_idx_q)
            3'd0:    pal_rgb = 6'b11_00_00;
            3'd1:    pal_rgb = 6'b11_11_00;
            3'd2:    pal_rgb = 6'b00_11_00;
            3'd3:    pal_rgb = 6'b00_11_11;
            3'd4:    pal_rgb = 6'b00_00_11;
            3'd5:    pal_rgb = 6'b11_00_11;
            default: pal_rgb = 6'b00_00_00;
        endcase
    end

    // Pick blanking, box colour or background, and delay the syncs by one
    // clock to match.
    always_comb begin
        in_box   = (x_ext >= bx_ext) && (x_ext < bx_end) &&
                   (y_ext >= by_ext) && (y_ext < by_end);
        h_sync_d = h_sync_in;
        v_sync_d = v_sync_in;
        r_d      = 2'd1;
        g_d      = 2'd1;
        b_d      = 2'd1;
        if (!frame_active) begin
            r_d = 2'd0;
            g_d = 2'd0;
            b_d = 2'd0;
        end else if (in_box) begin
            r_d = pal_rgb[5:4];
            g_d = pal_rgb[3:2];
            b_d = pal_rgb[1:0];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bx_q           <= 10'd0;
            by_q           <= 10'd0;
            dir_x_q        <= 1'b0;
            dir_y_q        <= 1'b0;
            pal_idx_q      <= 3'd0;
            bounce_count_q <= 8'd0;
            vs_prev_q      <= 1'b0;
            r_q            <= 2'd0;
            g_q            <= 2'd0;
            b_q            <= 2'd0;
            h_sync_q       <= 1'b0;
            v_sync_q       <= 1'b0;
        end else begin
            bx_q           <= bx_d;
            by_q           <= by_d;
            dir_x_q        <= dir_x_d;
            dir_y_q        <= dir_y_d;
            pal_idx_q      <= pal_idx_d;
            bounce_count_q <= bounce_count_d;
            vs_prev_q      <= vs_prev_d;
            r_q            <= r_d;
            g_q            <= g_d;
            b_q            <= b_d;
            h_sync_q       <= h_sync_d;
            v_sync_q       <= v_sync_d;
        end
    end

    assign r            = r_q;
    assign g            = g_q;
    assign b            = b_q;
    assign h_sync       = h_sync_q;
    assign v_sync       = v_sync_q;
    assign bounce_count = bounce_count_q;

endmodule

// File: tb/tb_vga_bounce_renderer.sv
// Directed bench for vga_bounce_renderer. Three instances cover the default
// geometry, a 64x64 screen where the box hits corners, and a narrow screen
// with SPEED=3 for the left-edge clamp.
module tb_vga_bounce_renderer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [9:0] x, y;
    logic       h_sync_in, frame_active, pause;
    logic       vs_a, vs_b, vs_c;

    logic [1:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic       hs_a, vs_o_a, hs_b, vs_o_b, hs_c, vs_o_c;
    logic [7:0] bc_a, bc_b, bc_c;

    int n_checks = 0;
    int n_pass   = 0;

    vga_bounce_renderer dut_a (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .h_sync_in(h_sync_in),
        .v_sync_in(vs_a), .frame_active(frame_active), .pause(pause),
        .r(r_a), .g(g_a), .b(b_a), .h_sync(hs_a), .v_sync(vs_o_a),
        .bounce_count(bc_a)
    );

    vga_bounce_renderer #(.DISP_W(64), .DISP_H(64), .BOX_SIZE(32), .SPEED(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .h_sync_in(h_sync_in),
        .v_sync_in(vs_b), .frame_active(frame_active), .pause(pause),
        .r(r_b), .g(g_b), .b(b_b), .h_sync(hs_b), .v_sync(vs_o_b),
        .bounce_count(bc_b)
    );

    vga_bounce_renderer #(.DISP_W(40), .DISP_H(480), .BOX_SIZE(32), .SPEED(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .h_sync_in(h_sync_in),
        .v_sync_in(vs_c), .frame_active(frame_active), .pause(pause),
        .r(r_c), .g(g_c), .b(b_c), .h_sync(hs_c), .v_sync(vs_o_c),
        .bounce_count(bc_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // One v_sync pulse (rising edge then low) on the selected instance.
    task automatic tick(input int sel);
        vs_a = (sel == 0);
        vs_b = (sel == 1);
        vs_c = (sel == 2);
        step();
        vs_a = 1'b0;
        vs_b = 1'b0;
        vs_c = 1'b0;
        step();
    endtask

    task automatic ticks(input int sel, input int n);
        for (int i = 0; i < n; i++) tick(sel);
    endtask

    initial begin
        rst_n = 1'b0; x = '0; y = '0; h_sync_in = 1'b0; frame_active = 1'b0;
        pause = 1'b0; vs_a = 1'b0; vs_b = 1'b0; vs_c = 1'b0;
        step();
        check("rst_rgb", {r_a, g_a, b_a}, 0);
        check("rst_hsync", hs_a, 0);
        check("rst_vsync", vs_o_a, 0);
        check("rst_bounce", bc_a, 0);
        check("rst_bx", dut_a.bx_q, 0);
        check("rst_by", dut_a.by_q, 0);
        rst_n = 1'b1;

        // Rendering and sync alignment at the reset position
        h_sync_in = 1'b1; frame_active = 1'b0;
        step();
        check("blank_rgb", {r_a, g_a, b_a}, 0);
        check("hsync_hi", hs_a, 1);
        h_sync_in = 1'b0; frame_active = 1'b1;
        step();
        check("box_00", {r_a, g_a, b_a}, 6'b11_00_00);
        check("hsync_lo", hs_a, 0);
        x = 10'd32;
        step();
        check("bg_32_0", {r_a, g_a, b_a}, 6'b01_01_01);
        x = 10'd31; y = 10'd31;
        step();
        check("box_31_31", {r_a, g_a, b_a}, 6'b11_00_00);
        y = 10'd32;
        step();
        check("bg_31_32", {r_a, g_a, b_a}, 6'b01_01_01);

        // Narrow screen, SPEED=3: right clamp, then left clamp at bx=2
        vs_c = 1'b1;
        step();
        check("c_vsync_hi", vs_o_c, 1);
        check("c_t1_bx", dut_c.bx_q, 3);
        vs_c = 1'b0;
        step();
        check("c_vsync_lo", vs_o_c, 0);
        ticks(2, 2);
        check("c_t3_bx", dut_c.bx_q, 8);
        check("c_t3_bounce", bc_c, 1);
        ticks(2, 2);
        check("c_t5_bx", dut_c.bx_q, 2);
        check("c_t5_dir", dut_c.dir_x_q, 1);
        tick(2);
        check("c_t6_bx", dut_c.bx_q, 0);
        check("c_t6_dir", dut_c.dir_x_q, 0);
        check("c_t6_bounce", bc_c, 2);
        tick(2);
        check("c_t7_bx", dut_c.bx_q, 3);

        // Default geometry: bottom bounce at 224, right bounce at 304
        ticks(0, 223);
        check("a_t223_by", dut_a.by_q, 446);
        check("a_t223_pal", dut_a.pal_idx_q, 0);
        tick(0);
        check("a_t224_by", dut_a.by_q, 448);
        check("a_t224_bx", dut_a.bx_q, 448);
        check("a_t224_diry", dut_a.dir_y_q, 1);
        check("a_t224_pal", dut_a.pal_idx_q, 1);
        check("a_t224_bounce", bc_a, 1);
        ticks(0, 79);
        check("a_t303_bx", dut_a.bx_q, 606);
        tick(0);
        check("a_t304_bx", dut_a.bx_q, 608);
        check("a_t304_by", dut_a.by_q, 288);
        check("a_t304_dirx", dut_a.dir_x_q, 1);
        check("a_t304_pal", dut_a.pal_idx_q, 2);
        check("a_t304_bounce", bc_a, 2);
        tick(0);
        check("a_t305_bx", dut_a.bx_q, 606);
        check("a_t305_by", dut_a.by_q, 286);

        // Box edges at (606,286), palette entry 2
        x = 10'd606; y = 10'd286;
        step();
        check("a_box_tl", {r_a, g_a, b_a}, 6'b00_11_00);
        x = 10'd605;
        step();
        check("a_left_out", {r_a, g_a, b_a}, 6'b01_01_01);
        x = 10'd637; y = 10'd317;
        step();
        check("a_box_br", {r_a, g_a, b_a}, 6'b00_11_00);
        x = 10'd638;
        step();
        check("a_right_out", {r_a, g_a, b_a}, 6'b01_01_01);

        // Pause discards ticks; releasing it mid-frame gives no catch-up
        pause = 1'b1;
        ticks(0, 3);
        check("pause_bx", dut_a.bx_q, 606);
        check("pause_by", dut_a.by_q, 286);
        check("pause_pal", dut_a.pal_idx_q, 2);
        check("pause_bounce", bc_a, 2);
        vs_a = 1'b1;
        step();
        pause = 1'b0;
        step();
        check("release_hold_bx", dut_a.bx_q, 606);
        vs_a = 1'b0;
        step();
        tick(0);
        check("release_bx", dut_a.bx_q, 604);
        check("release_by", dut_a.by_q, 284);

        // 64x64 screen: corner hit every 8 ticks counts one bounce
        ticks(1, 7);
        check("b_t7_bx", dut_b.bx_q, 28);
        check("b_t7_bounce", bc_b, 0);
        tick(1);
        check("b_t8_bx", dut_b.bx_q, 32);
        check("b_t8_by", dut_b.by_q, 32);
        check("b_t8_dirx", dut_b.dir_x_q, 1);
        check("b_t8_diry", dut_b.dir_y_q, 1);
        check("b_t8_pal", dut_b.pal_idx_q, 1);
        check("b_t8_bounce", bc_b, 1);
        ticks(1, 2032);
        check("b_255_bounce", bc_b, 255);
        check("b_255_pal", dut_b.pal_idx_q, 3);
        ticks(1, 8);
        check("b_wrap_bounce", bc_b, 0);
        check("b_wrap_pal", dut_b.pal_idx_q, 4);
        check("b_wrap_bx", dut_b.bx_q, 0);
        tick(1);
        check("b_t2049_bx", dut_b.bx_q, 4);
        x = 10'd4; y = 10'd4; frame_active = 1'b1;
        step();
        check("b_pal4_rgb", {r_b, g_b, b_b}, 6'b00_00_11);

        // One-clock reset mid-line clears box state and outputs
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("b_rst_rgb", {r_b, g_b, b_b}, 0);
        check("b_rst_bx", dut_b.bx_q, 0);
        check("b_rst_pal", dut_b.pal_idx_q, 0);
        check("b_rst_bounce", bc_b, 0);
        check("b_rst_dirx", dut_b.dir_x_q, 0);
        check("a_rst_bx", dut_a.bx_q, 0);
        step();
        check("b_post_rst_rgb", {r_b, g_b, b_b}, 6'b11_00_00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_bounce_renderer.md
Name: vga_bounce_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA timing controller.
- Consumes the beam position (x, y), the registered sync pulses and frame_active; produces 2-bit-per-channel RGB plus re-aligned syncs for the Tiny Tapeout VGA PMOD.
- Draws a solid square that moves once per frame, bounces off the screen edges and steps through a 6-entry colour palette on every bounce, over a dim grey background.

Parameters:
- DISP_W, 640, visible width in pixels; right bounce limit derives from it.
- DISP_H, 480, visible height in lines; bottom bounce limit derives from it.
- BOX_SIZE, 32, box edge length in pixels.
- SPEED, 2, pixels moved per axis per frame tick (1..BOX_SIZE).

Ports:
- clk  input  1  pixel clock, shared with the timing controller.
- rst_n  input  1  synchronous active-low reset.
- x  input  10  current beam column.
- y  input  10  current beam row.
- h_sync_in  input  1  horizontal sync from the timing controller.
- v_sync_in  input  1  vertical sync from the timing controller.
- frame_active  input  1  beam inside the visible area.
- pause  input  1  when high, frame ticks are ignored and the box holds position.
- r  output  2  red intensity.
- g  output  2  green intensity.
- b  output  2  blue intensity.
- h_sync  output  1  h_sync_in delayed 1 clk.
- v_sync  output  1  v_sync_in delayed 1 clk.
- bounce_count  output  8  bounce events since reset; wraps 255->0.

Behaviour:
- Reset: one clock, synchronous, active-low; sampled on posedge clk.
  - Clears r, g, b, h_sync, v_sync, bounce_count and the v_sync edge register to 0.
  - Sets bx=0, by=0, dir_x=+, dir_y=+, pal_idx=0.
  - Reset asserted mid-frame takes effect at the next edge; there is no partial update.
- Latency: exactly 1 clk.
  - r/g/b at cycle t+1 are a function of x, y, frame_active and box state sampled at cycle t.
  - h_sync and v_sync at t+1 equal h_sync_in and v_sync_in at t, so colour and syncs stay mutually aligned.
- Frame tick: tick = v_sync_in & ~v_sync_in_d, where v_sync_in_d is a registered copy. A tick with pause=1 is discarded, not deferred.
- Position update, once per tick, with X_MAX=DISP_W-BOX_SIZE and Y_MAX=DISP_H-BOX_SIZE:
  - X, dir +: if bx+SPEED >= X_MAX then bx<=X_MAX and dir_x flips to -; else bx<=bx+SPEED.
  - X, dir -: if bx <= SPEED then bx<=0 and dir_x flips to +; else bx<=bx-SPEED.
  - Y axis uses identical rules with by, dir_y and Y_MAX.
  - All sums and compares use 11 bits; no 10-bit wrap is permitted.
- Bounce: a tick where either axis flips.
  - pal_idx advances 0,1,2,3,4,5,0 and bounce_count increments by 1.
  - A corner hit (both axes flip on the same tick) still advances pal_idx and bounce_count by exactly 1.
- Palette as r,g,b: 0=3,0,0; 1=3,3,0; 2=0,3,0; 3=0,3,3; 4=0,0,3; 5=3,0,3.
- Pixel select, registered, in priority order:
  1. frame_active=0 -> r,g,b = 0,0,0.
  2. bx <= x < bx+BOX_SIZE and by <= y < by+BOX_SIZE -> palette[pal_idx].
  3. Otherwise -> background 1,1,1.
- Box state changes only on the tick edge, so a frame is never drawn with two box positions.

Test Plan:
- Reset then free-run timing: r,g,b=0 during blanking. At x=0,y=0 the next cycle gives 3,0,0. At x=32,y=0 it gives 1,1,1. h_sync/v_sync equal the inputs delayed 1 clk.
- Default params, pause=0, count ticks: bx=2n, by=2n. Tick 224: by=448, dir_y flips, pal_idx=1, bounce_count=1. Tick 304: bx=608, dir_x flips, pal_idx=2, bounce_count=2. Tick 305: bx=606.
- DISP_W=64, DISP_H=64, BOX_SIZE=32, SPEED=4: tick 8 gives bx=by=32 with both axes flipping; pal_idx=1 and bounce_count=1, not 2.
- pause=1 across 3 v_sync rising edges: bx, by, pal_idx and bounce_count are unchanged. Releasing pause mid-frame gives no catch-up; the next edge moves the box by exactly SPEED.
- SPEED=3, box moving left at bx=2: next tick gives bx=0 and dir_x=+. The following tick gives bx=3.
- Assert rst_n=0 for 1 clk mid-line with bx=100 and pal_idx=4: the next cycle has bx=0, pal_idx=0, outputs 0. bounce_count reaches 255 then 0 after 256 bounces.
